// File: rtl/div_pkg.sv
// Shared definitions for the shift-and-subtract divider: FSM encoding and the
// default operand width shared with the companion multiplier.
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference if it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {1'b0, divisor_i};
  assign q_bit_o = ~trial[WIDTH];

  // The kept value is always below the divisor, so it fits in WIDTH bits.
  assign rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule : div_step

// File: rtl/shift_subtract_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake and a single-cycle divide-by-zero shortcut.
module shift_subtract_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] shq_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] rem_d;
  logic             q_bit_d;
  logic [WIDTH-1:0] shq_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (shq_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit_d)
  );

  assign shq_d = {shq_q[WIDTH-2:0], q_bit_d};

  // NOTE: every register here updates with <= so all state moves together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      shq_q       <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            divisor_q <= divisor;
            shq_q     <= dividend;
            rem_q     <= '0;
            cnt_q     <= CNT_W'(WIDTH);
            dbz_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end else begin
            state_q   <= S_IDLE;
          end
        end

        S_RUN: begin
          if (divisor_q == '0) begin
            // Dividend still sits untouched in the shift register on the first RUN cycle.
            quotient_q  <= '1;
            remainder_q <= shq_q;
            dbz_q       <= 1'b1;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            rem_q <= rem_d;
            shq_q <= shq_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              quotient_q  <= shq_d;
              remainder_q <= rem_d;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : shift_subtract_divider

// File: tb/tb_shift_subtract_divider.sv
// Directed self-checking bench for shift_subtract_divider (WIDTH=4).
module tb_shift_subtract_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec;
  int n_err;

  shift_subtract_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then count edges until done is seen (bounded).
  // Returns latency in edges after the accepting edge, busy cycles seen before
  // done, whether done was seen, and done one cycle later.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cyc,
                        output logic seen, output logic done_after);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    lat = 0; busy_cyc = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    seen = done;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bc; logic seen, da;
    run_op(4'd13, 4'd3, lat, bc, seen, da);
    n_vec++;
    if (!seen || lat != 4) begin
      n_err++; $display("FAIL basic_latency: got seen=%b lat=%0d, want 1 4", seen, lat);
    end
    n_vec++;
    if (bc != 4) begin n_err++; $display("FAIL basic_busy_cycles: got %0d, want 4", bc); end
    n_vec++;
    if (da !== 1'b0) begin n_err++; $display("FAIL basic_done_width: done still %b, want 0", da); end
    n_vec++;
    if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL basic_13_3: got q=%0d r=%0d dbz=%b, want q=4 r=1 dbz=0",
               quotient, remainder, div_by_zero);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (quotient !== 4'd4 || remainder !== 4'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: got q=%0d r=%0d busy=%b, want q=4 r=1 busy=0",
               quotient, remainder, busy);
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bc; logic seen, da;
    run_op(4'd7, 4'd0, lat, bc, seen, da);
    n_vec++;
    if (!seen || lat != 1) begin
      n_err++; $display("FAIL dbz_latency: got seen=%b lat=%0d, want 1 1", seen, lat);
    end
    n_vec++;
    if (quotient !== 4'd15 || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
      n_err++;
      $display("FAIL dbz_7_0: got q=%0d r=%0d dbz=%b, want q=15 r=7 dbz=1",
               quotient, remainder, div_by_zero);
    end
    run_op(4'd15, 4'd1, lat, bc, seen, da);
    n_vec++;
    if (!seen || quotient !== 4'd15 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL after_dbz_15_1: got seen=%b q=%0d r=%0d dbz=%b, want 1 q=15 r=0 dbz=0",
               seen, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_small_large();
    int lat, bc; logic seen, da;
    run_op(4'd2, 4'd9, lat, bc, seen, da);
    n_vec++;
    if (!seen || quotient !== 4'd0 || remainder !== 4'd2) begin
      n_err++;
      $display("FAIL div_2_9: got seen=%b q=%0d r=%0d, want 1 q=0 r=2", seen, quotient, remainder);
    end
    run_op(4'd15, 4'd15, lat, bc, seen, da);
    n_vec++;
    if (!seen || quotient !== 4'd1 || remainder !== 4'd0) begin
      n_err++;
      $display("FAIL div_15_15: got seen=%b q=%0d r=%0d, want 1 q=1 r=0", seen, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);                                   // E0
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);                                   // E1
    @(negedge clk);
    // Held high from here through RUN and into DONE.
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_vec++;
    if (!done || lat != 4) begin
      n_err++; $display("FAIL run_ignore_latency: got done=%b lat=%0d, want 1 4", done, lat);
    end
    n_vec++;
    if (quotient !== 4'd4 || remainder !== 4'd1) begin
      n_err++;
      $display("FAIL run_ignore_13_3: got q=%0d r=%0d, want q=4 r=1", quotient, remainder);
    end
    @(posedge clk);                                   // accepted from DONE
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got done=%b busy=%b, want done=0 busy=1", done, busy);
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_vec++;
    if (!done || lat != 4 || quotient !== 4'd4 || remainder !== 4'd1) begin
      n_err++;
      $display("FAIL b2b_9_2: got done=%b lat=%0d q=%0d r=%0d, want 1 4 q=4 r=1",
               done, lat, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, done_hits; logic seen, da;
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) done_hits++;
    end
    n_vec++;
    if (done_hits != 0) begin
      n_err++; $display("FAIL midrun_no_done: got %0d active cycles, want 0", done_hits);
    end
    run_op(4'd14, 4'd3, lat, bc, seen, da);
    n_vec++;
    if (!seen || quotient !== 4'd4 || remainder !== 4'd2) begin
      n_err++;
      $display("FAIL after_reset_14_3: got seen=%b q=%0d r=%0d, want 1 q=4 r=2",
               seen, quotient, remainder);
    end
  endtask

  task automatic test_sweep();
    int lat, bc; logic seen, da;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), lat, bc, seen, da);
        n_vec++;
        if (!seen || da !== 1'b0) begin
          n_err++;
          $display("FAIL sweep_done %0d/%0d: got seen=%b done_next=%b, want 1 0", a, b, seen, da);
        end
        n_vec++;
        if (b == 0) begin
          if (quotient !== 4'd15 || remainder !== W'(a) || div_by_zero !== 1'b1) begin
            n_err++;
            $display("FAIL sweep_dbz %0d/0: got q=%0d r=%0d dbz=%b, want q=15 r=%0d dbz=1",
                     a, quotient, remainder, div_by_zero, a);
          end
        end else begin
          if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b
              || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_inv %0d/%0d: got q=%0d r=%0d dbz=%b, want q*b+r=a r<b dbz=0",
                     a, b, quotient, remainder, div_by_zero);
          end
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_div_by_zero();
    test_small_large();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_shift_subtract_divider
